// File: rtl/des_round_sequencer.sv
// Iterative DES round sequencer: one block at a time through NUM_ROUNDS Feistel rounds,
// sharing a single combinational Feistel function and key-schedule lookup.
module des_round_sequencer #(
  parameter int NUM_ROUNDS = 16,
  parameter int ROUND_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               decrypt,
  input  logic [63:0]        block_in,
  output logic [ROUND_W-1:0] round_idx,
  input  logic [47:0]        key_in,
  output logic [47:0]        feistel_round_key,
  output logic [31:0]        feistel_input,
  input  logic [31:0]        feistel_output,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        block_out,
  output logic               busy,
  output logic [1:0]         fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready depends only on state, and out_valid/block_out hold until out_ready is seen.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

  state_t             state, state_nxt;
  logic [31:0]        l_q, l_nxt;
  logic [31:0]        r_q, r_nxt;
  logic [ROUND_W-1:0] cnt, cnt_nxt;
  logic               mode, mode_nxt;
  logic [63:0]        out_q, out_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      l_q   <= '0;
      r_q   <= '0;
      cnt   <= '0;
      mode  <= 1'b0;
      out_q <= '0;
    end else begin
      state <= state_nxt;
      l_q   <= l_nxt;
      r_q   <= r_nxt;
      cnt   <= cnt_nxt;
      mode  <= mode_nxt;
      out_q <= out_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    l_nxt     = l_q;
    r_nxt     = r_q;
    cnt_nxt   = cnt;
    mode_nxt  = mode;
    out_nxt   = out_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          l_nxt     = block_in[63:32];
          r_nxt     = block_in[31:0];
          mode_nxt  = decrypt;
          cnt_nxt   = '0;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        l_nxt = r_q;
        r_nxt = l_q ^ feistel_output;
        if (cnt == LAST_ROUND) begin
          // Final swap folded in: result is {R16, L16}.
          out_nxt   = {l_q ^ feistel_output, r_q};
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    round_idx = '0;
    if (state == ROUND) begin
      round_idx = mode ? (LAST_ROUND - cnt) : cnt;
    end
  end

  assign in_ready          = (state == IDLE);
  assign out_valid         = (state == DONE);
  assign busy              = (state != IDLE);
  assign feistel_input     = r_q;
  assign feistel_round_key = key_in;
  assign block_out         = out_q;
  assign fsm_state         = state;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Directed bench for des_round_sequencer with a behavioural Feistel/key stub and an
// expected-result queue filled on accept and drained on the output handshake.
module tb_des_round_sequencer;

  localparam int NR = 16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        decrypt;
  logic [63:0] block_in;
  logic [3:0]  round_idx;
  logic [47:0] key_in;
  logic [47:0] feistel_round_key;
  logic [31:0] feistel_input;
  logic [31:0] feistel_output;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] block_out;
  logic        busy;
  logic [1:0]  fsm_state;

  int          passed = 0;
  int          total  = 0;
  int          f_sel  = 0;
  int          key_sel = 0;
  logic [47:0] key_tab [16];
  logic [63:0] exp_q [$];

  des_round_sequencer #(.NUM_ROUNDS(NR), .ROUND_W(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .decrypt           (decrypt),
    .block_in          (block_in),
    .round_idx         (round_idx),
    .key_in            (key_in),
    .feistel_round_key (feistel_round_key),
    .feistel_input     (feistel_input),
    .feistel_output    (feistel_output),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .block_out         (block_out),
    .busy              (busy),
    .fsm_state         (fsm_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", passed, total);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
    logic [31:0] a;
    case (f_sel)
      0: f_model = 32'h0;
      1: f_model = r ^ k[31:0];
      default: begin
        a = r ^ k[31:0];
        a = a + {k[47:32], k[47:32]};
        f_model = {a[18:0], a[31:19]} ^ (a * 32'h9E3779B1);
      end
    endcase
  endfunction

  function automatic logic [47:0] key_model(input logic [3:0] idx);
    if (key_sel == 0) key_model = {12{idx}};
    else              key_model = key_tab[idx];
  endfunction

  function automatic logic [63:0] des_model(input logic [63:0] blk, input logic dec);
    logic [31:0] l, r, t;
    logic [3:0]  idx;
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 0; i < NR; i++) begin
      idx = dec ? 4'(NR - 1 - i) : 4'(i);
      t = r;
      r = l ^ f_model(r, key_model(idx));
      l = t;
    end
    des_model = {r, l};
  endfunction

  assign key_in         = key_model(round_idx);
  assign feistel_output = f_model(feistel_input, feistel_round_key);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Driver: one block from accept through output handshake; starts and ends at a negedge.
  task automatic run_block(input logic [63:0] blk, input logic dec, input int hold,
                           output logic [63:0] result);
    logic [31:0] l, r, t;
    logic [3:0]  idx;
    logic [63:0] exp;
    int          w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_idle", in_ready, 1);
    block_in = blk;
    decrypt  = dec;
    in_valid = 1'b1;
    exp_q.push_back(des_model(blk, dec));
    @(negedge clk);
    in_valid = 1'b0;
    decrypt  = ~dec;
    block_in = {$urandom, $urandom};
    l = blk[63:32];
    r = blk[31:0];
    for (int k = 0; k < NR; k++) begin
      idx = dec ? 4'(NR - 1 - k) : 4'(k);
      check("round_idx", round_idx, idx);
      check("feistel_input", feistel_input, r);
      check("round_key", feistel_round_key, key_model(idx));
      check("flags_round", {busy, in_ready, out_valid}, 3'b100);
      t = r;
      r = l ^ f_model(r, key_model(idx));
      l = t;
      @(negedge clk);
    end
    check("latency_out_valid", out_valid, 1);
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    exp = exp_q.pop_front();
    if (!out_valid) begin
      check("out_valid_timeout", out_valid, 1);
      result = '0;
      return;
    end
    check("block_out", block_out, exp);
    check("round_idx_done", round_idx, 0);
    result = block_out;
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      in_valid  = k[0];
      block_in  = {$urandom, $urandom};
      @(negedge clk);
      check("block_out_stall", block_out, exp);
      check("flags_stall", {out_valid, in_ready, busy}, 3'b101);
    end
    in_valid  = 1'b1;
    block_in  = {$urandom, $urandom};
    out_ready = 1'b1;
    @(negedge clk);
    check("flags_after_handshake", {out_valid, in_ready, busy}, 3'b010);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] x, y, z;
    int          seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    decrypt   = 1'b0;
    block_in  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) key_tab[i] = '0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_block_out", block_out, 0);
    check("reset_round_idx", round_idx, 0);

    // Zero Feistel function: output is just the half swap.
    f_sel = 0;
    key_sel = 0;
    run_block(64'h0123456789ABCDEF, 1'b0, 0, y);
    check("stub0_encrypt", y, 64'h89ABCDEF01234567);
    run_block(64'h0123456789ABCDEF, 1'b1, 0, y);
    check("stub0_decrypt", y, 64'h89ABCDEF01234567);

    // f = R ^ K with K = round index replicated.
    f_sel = 1;
    for (int i = 0; i < 6; i++) begin
      run_block({$urandom, $urandom}, 1'(i), $urandom_range(0, 2), y);
    end

    // Nonlinear f with random key table: encrypt then decrypt must recover the input.
    f_sel = 2;
    key_sel = 1;
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 0) begin
        for (int j = 0; j < 16; j++) key_tab[j] = {$urandom, $urandom};
      end
      x = {$urandom, $urandom};
      run_block(x, 1'b0, 0, y);
      run_block(y, 1'b1, $urandom_range(0, 3), z);
      check("round_trip", z, x);
    end

    // Long output stall with in_valid pulses, then an immediate follow-on block.
    run_block({$urandom, $urandom}, 1'b0, 10, y);
    run_block({$urandom, $urandom}, 1'b1, 0, y);

    // Reset during round 7 discards the block.
    f_sel = 1;
    key_sel = 0;
    block_in = {$urandom, $urandom};
    decrypt  = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("midrst_busy_before", busy, 1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_flags", {in_ready, busy, out_valid}, 3'b100);
    check("midrst_round_idx", round_idx, 0);
    check("midrst_block_out", block_out, 0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("midrst_no_output", seen, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
